bcd_timer_ctrl: RTL and testbench

Four-digit BCD timer controller that sequences four `BCD_counter` digit instances as one 0000–9999 count. It provides a tick prescaler, up/down direction, preset loading and a run/pause/done state machine. Digit carries are generated from terminal-count detection on digit values. The block sits between the front-panel control logic and the seven-segment display path, which consumes `COUNT`.

---
 rtl/bcd_pkg.sv | 23 ++
 rtl/BCD_counter.sv | 37 +++
 rtl/bcd_timer_ctrl.sv | 113 +++++++++++
 tb/tb_bcd_timer_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and helpers for the four-digit BCD timer.
package bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_MIN = 4'd0;

  function automatic logic is_valid_bcd16(input logic [15:0] v);
    logic ok;
    ok = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      if (v[i*4 +: 4] > BCD_MAX) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/BCD_counter.sv
// Single BCD digit: up/down with 9<->0 wrap, synchronous load, async active-low clear.
module BCD_counter
  import bcd_pkg::*;
(
  input  logic       CLK,
  input  logic       CLR_N,
  input  logic       EN,
  input  logic       LOAD_EN,
  input  logic       DIR,
  input  logic [3:0] D,
  output logic [3:0] Q,
  output logic       OF,
  output logic       UF
);

  logic [3:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (LOAD_EN) begin
      q_d = D;
    end else if (EN) begin
      if (DIR) q_d = (q_q == BCD_MAX) ? BCD_MIN : q_q + 4'd1;
      else     q_d = (q_q == BCD_MIN) ? BCD_MAX : q_q - 4'd1;
    end
  end

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) q_q <= '0;
    else        q_q <= q_d;
  end

  assign Q  = q_q;
  assign OF = EN && !LOAD_EN && DIR  && (q_q == BCD_MAX);
  assign UF = EN && !LOAD_EN && !DIR && (q_q == BCD_MIN);

endmodule

// File: rtl/bcd_timer_ctrl.sv
// Four-digit BCD timer: prescaled tick, up/down, preset load, IDLE/RUN/PAUSE/DONE control.
module bcd_timer_ctrl
  import bcd_pkg::*;
#(
  parameter int unsigned TICK_DIV = 4
) (
  input  logic        CLK,
  input  logic        CLR,
  input  logic        START,
  input  logic        STOP,
  input  logic        DIR,
  input  logic        PRESET_EN,
  input  logic [15:0] PRESET,
  output logic [15:0] COUNT,
  output logic        RUNNING,
  output logic        DONE,
  output logic        ERR
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          dir_q, dir_d;
  logic          err_q, err_d;

  logic        tick, load_ok, done_hit, start_term;
  logic [3:0]  term;
  logic [3:0]  dig_en;
  logic [15:0] cnt;

  assign tick    = (state_q == ST_RUN) && (presc_q == PRESC_MAX);
  assign load_ok = PRESET_EN && is_valid_bcd16(PRESET);

  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      term[i] = dir_q ? (cnt[i*4 +: 4] == BCD_MAX) : (cnt[i*4 +: 4] == BCD_MIN);
    end
    dig_en[0] = tick;
    dig_en[1] = tick && term[0];
    dig_en[2] = tick && term[0] && term[1];
    dig_en[3] = tick && term[0] && term[1] && term[2];
  end

  // Only the immediate predecessor of the terminal value can reach it on a tick.
  assign done_hit   = tick && (dir_q ? (cnt == 16'h9998) : (cnt == 16'h0001));
  assign start_term = DIR ? (cnt == 16'h9999) : (cnt == 16'h0000);

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    dir_d   = dir_q;
    err_d   = 1'b0;
    if (load_ok) begin
      state_d = ST_IDLE;
      presc_d = '0;
    end else begin
      err_d = PRESET_EN;
      case (state_q)
        ST_IDLE: begin
          if (START && !PRESET_EN) begin
            dir_d   = DIR;
            state_d = start_term ? ST_DONE : ST_RUN;
            presc_d = '0;
          end
        end
        ST_RUN: begin
          if (done_hit) begin
            state_d = ST_DONE;
          end else if (STOP && !PRESET_EN) begin
            state_d = ST_PAUSE;
          end else begin
            presc_d = tick ? '0 : presc_q + PW'(1);
          end
        end
        ST_PAUSE: begin
          if (START && !STOP && !PRESET_EN) state_d = ST_RUN;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_q <= ST_IDLE;
      presc_q <= '0;
      dir_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      dir_q   <= dir_d;
      err_q   <= err_d;
    end
  end

  BCD_counter u_dig0 (.CLK(CLK), .CLR_N(~CLR), .EN(dig_en[0]), .LOAD_EN(load_ok), .DIR(dir_q),
                      .D(PRESET[3:0]),   .Q(cnt[3:0]),   .OF(), .UF());
  BCD_counter u_dig1 (.CLK(CLK), .CLR_N(~CLR), .EN(dig_en[1]), .LOAD_EN(load_ok), .DIR(dir_q),
                      .D(PRESET[7:4]),   .Q(cnt[7:4]),   .OF(), .UF());
  BCD_counter u_dig2 (.CLK(CLK), .CLR_N(~CLR), .EN(dig_en[2]), .LOAD_EN(load_ok), .DIR(dir_q),
                      .D(PRESET[11:8]),  .Q(cnt[11:8]),  .OF(), .UF());
  BCD_counter u_dig3 (.CLK(CLK), .CLR_N(~CLR), .EN(dig_en[3]), .LOAD_EN(load_ok), .DIR(dir_q),
                      .D(PRESET[15:12]), .Q(cnt[15:12]), .OF(), .UF());

  assign COUNT   = cnt;
  assign RUNNING = (state_q == ST_RUN);
  assign DONE    = (state_q == ST_DONE);
  assign ERR     = err_q;

endmodule

// File: tb/tb_bcd_timer_ctrl.sv
// Directed bench for bcd_timer_ctrl with TICK_DIV = 4.
module tb_bcd_timer_ctrl;

  logic        CLK = 1'b0;
  logic        CLR = 1'b1;
  logic        START = 1'b0;
  logic        STOP = 1'b0;
  logic        DIR = 1'b0;
  logic        PRESET_EN = 1'b0;
  logic [15:0] PRESET = '0;
  logic [15:0] COUNT;
  logic        RUNNING, DONE, ERR;

  int checks = 0;
  int failures = 0;

  bcd_timer_ctrl #(.TICK_DIV(4)) dut (
    .CLK(CLK), .CLR(CLR), .START(START), .STOP(STOP), .DIR(DIR),
    .PRESET_EN(PRESET_EN), .PRESET(PRESET),
    .COUNT(COUNT), .RUNNING(RUNNING), .DONE(DONE), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic do_preset(input logic [15:0] v);
    PRESET = v;
    PRESET_EN = 1'b1;
    step(1);
    PRESET_EN = 1'b0;
  endtask

  task automatic do_start(input logic d);
    DIR = d;
    START = 1'b1;
    step(1);
    START = 1'b0;
  endtask

  task automatic test_reset;
    #12;
    checks++;
    if (COUNT !== 16'h0000 || RUNNING !== 1'b0 || DONE !== 1'b0 || ERR !== 1'b0) begin
      failures++;
      $display("FAIL reset: got count=%h run=%b done=%b err=%b want 0000 0 0 0", COUNT, RUNNING, DONE, ERR);
    end
    @(negedge CLK);
    CLR = 1'b0;
    step(1);
  endtask

  task automatic test_countdown;
    do_preset(16'h0012);
    checks++;
    if (COUNT !== 16'h0012) begin
      failures++; $display("FAIL preset_load: got %h want 0012", COUNT);
    end
    do_start(1'b0);
    checks++;
    if (RUNNING !== 1'b1 || COUNT !== 16'h0012) begin
      failures++; $display("FAIL run_entry: got run=%b count=%h want 1 0012", RUNNING, COUNT);
    end
    step(3);
    checks++;
    if (COUNT !== 16'h0012) begin
      failures++; $display("FAIL pre_tick: got %h want 0012", COUNT);
    end
    step(1);
    checks++;
    if (COUNT !== 16'h0011) begin
      failures++; $display("FAIL first_tick: got %h want 0011", COUNT);
    end
    step(43);
    checks++;
    if (COUNT !== 16'h0001 || RUNNING !== 1'b1) begin
      failures++; $display("FAIL edge47: got count=%h run=%b want 0001 1", COUNT, RUNNING);
    end
    step(1);
    checks++;
    if (COUNT !== 16'h0000 || DONE !== 1'b1 || RUNNING !== 1'b0) begin
      failures++; $display("FAIL edge48_done: got count=%h done=%b run=%b want 0000 1 0", COUNT, DONE, RUNNING);
    end
    step(8);
    checks++;
    if (COUNT !== 16'h0000 || DONE !== 1'b1) begin
      failures++; $display("FAIL done_hold_down: got count=%h done=%b want 0000 1", COUNT, DONE);
    end
  endtask

  task automatic test_carry_up;
    do_preset(16'h0999);
    checks++;
    if (DONE !== 1'b0) begin
      failures++; $display("FAIL preset_leaves_done: got done=%b want 0", DONE);
    end
    do_start(1'b1);
    step(4);
    checks++;
    if (COUNT !== 16'h1000) begin
      failures++; $display("FAIL ripple_carry: got %h want 1000", COUNT);
    end
    do_preset(16'h9998);
    do_start(1'b1);
    step(4);
    checks++;
    if (COUNT !== 16'h9999 || DONE !== 1'b1 || RUNNING !== 1'b0) begin
      failures++; $display("FAIL up_done: got count=%h done=%b run=%b want 9999 1 0", COUNT, DONE, RUNNING);
    end
    step(20);
    checks++;
    if (COUNT !== 16'h9999 || DONE !== 1'b1) begin
      failures++; $display("FAIL up_hold: got count=%h done=%b want 9999 1", COUNT, DONE);
    end
    do_start(1'b0);
    step(8);
    checks++;
    if (COUNT !== 16'h9999 || DONE !== 1'b1 || RUNNING !== 1'b0) begin
      failures++; $display("FAIL start_in_done: got count=%h done=%b run=%b want 9999 1 0", COUNT, DONE, RUNNING);
    end
  endtask

  task automatic test_pause_resume;
    do_preset(16'h0050);
    do_start(1'b0);
    step(2);
    STOP = 1'b1;
    step(1);
    STOP = 1'b0;
    checks++;
    if (RUNNING !== 1'b0 || DONE !== 1'b0) begin
      failures++; $display("FAIL stop_pause: got run=%b done=%b want 0 0", RUNNING, DONE);
    end
    step(10);
    checks++;
    if (COUNT !== 16'h0050) begin
      failures++; $display("FAIL pause_hold: got %h want 0050", COUNT);
    end
    do_start(1'b1);
    checks++;
    if (RUNNING !== 1'b1 || COUNT !== 16'h0050) begin
      failures++; $display("FAIL resume: got run=%b count=%h want 1 0050", RUNNING, COUNT);
    end
    step(1);
    checks++;
    if (COUNT !== 16'h0050) begin
      failures++; $display("FAIL resume_early: got %h want 0050", COUNT);
    end
    step(1);
    checks++;
    if (COUNT !== 16'h0049) begin
      failures++; $display("FAIL resume_tick: got %h want 0049 (dir held down)", COUNT);
    end
  endtask

  task automatic test_bad_preset;
    STOP = 1'b1;
    step(1);
    STOP = 1'b0;
    do_preset(16'h00A5);
    checks++;
    if (ERR !== 1'b1 || COUNT !== 16'h0049 || RUNNING !== 1'b0 || DONE !== 1'b0) begin
      failures++; $display("FAIL bad_preset: got err=%b count=%h run=%b done=%b want 1 0049 0 0", ERR, COUNT, RUNNING, DONE);
    end
    step(1);
    checks++;
    if (ERR !== 1'b0) begin
      failures++; $display("FAIL err_pulse: got %b want 0", ERR);
    end
    do_start(1'b0);
    checks++;
    if (RUNNING !== 1'b1) begin
      failures++; $display("FAIL paused_after_err: got run=%b want 1", RUNNING);
    end
  endtask

  task automatic test_async_clr;
    do_preset(16'h0347);
    do_start(1'b0);
    step(2);
    #2;
    CLR = 1'b1;
    #1;
    checks++;
    if (COUNT !== 16'h0000 || RUNNING !== 1'b0 || DONE !== 1'b0) begin
      failures++; $display("FAIL async_clr: got count=%h run=%b done=%b want 0000 0 0", COUNT, RUNNING, DONE);
    end
    #1;
    CLR = 1'b0;
    step(1);
    checks++;
    if (COUNT !== 16'h0000 || RUNNING !== 1'b0) begin
      failures++; $display("FAIL clr_release: got count=%h run=%b want 0000 0", COUNT, RUNNING);
    end
    do_start(1'b1);
    checks++;
    if (RUNNING !== 1'b1) begin
      failures++; $display("FAIL restart: got run=%b want 1", RUNNING);
    end
  endtask

  task automatic test_start_stop;
    START = 1'b1;
    STOP = 1'b1;
    step(1);
    START = 1'b0;
    STOP = 1'b0;
    checks++;
    if (RUNNING !== 1'b0 || DONE !== 1'b0) begin
      failures++; $display("FAIL start_stop: got run=%b done=%b want 0 0", RUNNING, DONE);
    end
    step(6);
    checks++;
    if (COUNT !== 16'h0000) begin
      failures++; $display("FAIL start_stop_hold: got %h want 0000", COUNT);
    end
  endtask

  task automatic test_start_terminal;
    do_preset(16'h0000);
    do_start(1'b0);
    checks++;
    if (DONE !== 1'b1 || RUNNING !== 1'b0 || COUNT !== 16'h0000) begin
      failures++; $display("FAIL start_terminal: got done=%b run=%b count=%h want 1 0 0000", DONE, RUNNING, COUNT);
    end
    step(8);
    checks++;
    if (COUNT !== 16'h0000) begin
      failures++; $display("FAIL no_wrap: got %h want 0000", COUNT);
    end
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_carry_up();
    test_pause_resume();
    test_bad_preset();
    test_async_clr();
    test_start_stop();
    test_start_terminal();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
